// File: rtl/stick_center_calibrator.sv
// Frame-paced rest-position calibration for the main stick and C-stick: debounce, settle, average, publish.
// Define STICK_SPREAD_CHECK_EN to add per-axis min/max tracking and reject calibrations where a stick moved.
module stick_center_calibrator #(
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int SETTLE_FRAMES   = 4,
   parameter int SAMPLE_LOG2     = 3,
   parameter int MAX_SPREAD      = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start_pause,
   input  logic [7:0] joy_x,
   input  logic [7:0] joy_y,
   input  logic [7:0] c_stick_x,
   input  logic [7:0] c_stick_y,
   output logic [7:0] joy_x_center,
   output logic [7:0] joy_y_center,
   output logic [7:0] c_stick_x_center,
   output logic [7:0] c_stick_y_center,
   output logic       cal_busy,
   output logic       cal_done,
   output logic       cal_error
);

   localparam int ACC_W = 8 + SAMPLE_LOG2;
   localparam int DEB_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int SET_W = $clog2(SETTLE_FRAMES + 1);
   localparam int SMP_W = SAMPLE_LOG2 + 1;

   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_FRAMES - 1);
   localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_FRAMES - 1);
   localparam logic [SMP_W-1:0] SMP_LAST   = SMP_W'((1 << SAMPLE_LOG2) - 1);
   localparam logic [7:0]       CENTER_RST = 8'd128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_SETTLE,
      S_SAMPLE,
      S_CHECK,
      S_WAIT_RELEASE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [DEB_W-1:0]   r_deb_cnt;
   logic [SET_W-1:0]   r_set_cnt;
   logic [SMP_W-1:0]   r_smp_cnt;
   logic [7:0]         w_axis   [4];
   logic [ACC_W-1:0]   r_acc    [4];
   logic [7:0]         r_center [4];
   logic               r_cal_done;
   logic               w_reject;
   logic               w_enter_sample;
   logic               w_arm;

   // Axis order 0..3: joy_x, joy_y, c_stick_x, c_stick_y.
   always_comb begin
      w_axis[0] = joy_x;
      w_axis[1] = joy_y;
      w_axis[2] = c_stick_x;
      w_axis[3] = c_stick_y;
   end

   // ------------------------------------------------------------------
   // State register and next-state logic
   // ------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (frame_tick && start_pause) begin
               w_next = (DEBOUNCE_FRAMES == 1) ? S_SETTLE : S_DEBOUNCE;
            end
         end
         S_DEBOUNCE: begin
            if (frame_tick) begin
               if (!start_pause) begin
                  w_next = S_IDLE;
               end else if (r_deb_cnt == DEB_LAST) begin
                  w_next = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (frame_tick && (r_set_cnt == SET_LAST)) begin
               w_next = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (frame_tick && (r_smp_cnt == SMP_LAST)) begin
               w_next = S_CHECK;
            end
         end
         S_CHECK: begin
            w_next = S_WAIT_RELEASE;
         end
         S_WAIT_RELEASE: begin
            if (frame_tick && !start_pause) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign w_arm          = (r_state == S_IDLE) && (w_next != S_IDLE);
   assign w_enter_sample = (r_state == S_SETTLE) && (w_next == S_SAMPLE);

   // ------------------------------------------------------------------
   // Frame counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_deb_cnt <= '0;
         r_set_cnt <= '0;
         r_smp_cnt <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               // Preloaded so the arming tick itself counts as the first debounce frame.
               r_deb_cnt <= DEB_W'(1);
               r_set_cnt <= '0;
            end
            S_DEBOUNCE: begin
               if (frame_tick && start_pause) begin
                  r_deb_cnt <= (r_deb_cnt == DEB_LAST) ? '0 : r_deb_cnt + 1'b1;
               end
            end
            S_SETTLE: begin
               if (frame_tick) begin
                  if (r_set_cnt == SET_LAST) begin
                     r_set_cnt <= '0;
                     r_smp_cnt <= '0;
                  end else begin
                     r_set_cnt <= r_set_cnt + 1'b1;
                  end
               end
            end
            S_SAMPLE: begin
               if (frame_tick) begin
                  r_smp_cnt <= r_smp_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Accumulators, published centers, done pulse
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int a = 0; a < 4; a++) begin
            r_acc[a]    <= '0;
            r_center[a] <= CENTER_RST;
         end
         r_cal_done <= 1'b0;
      end else begin
         r_cal_done <= 1'b0;
         for (int a = 0; a < 4; a++) begin
            if (w_enter_sample) begin
               r_acc[a] <= '0;
            end else if ((r_state == S_SAMPLE) && frame_tick) begin
               r_acc[a] <= r_acc[a] + ACC_W'(w_axis[a]);
            end
         end
         // All four centers commit on the same edge or not at all.
         if ((r_state == S_CHECK) && !w_reject) begin
            for (int a = 0; a < 4; a++) begin
               r_center[a] <= r_acc[a][ACC_W-1:SAMPLE_LOG2];
            end
            r_cal_done <= 1'b1;
         end
      end
   end

`ifdef STICK_SPREAD_CHECK_EN
   logic [7:0] r_min [4];
   logic [7:0] r_max [4];
   logic       r_cal_error;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int a = 0; a < 4; a++) begin
            r_min[a] <= '0;
            r_max[a] <= '0;
         end
      end else begin
         for (int a = 0; a < 4; a++) begin
            if (w_enter_sample) begin
               r_min[a] <= '0;
               r_max[a] <= '0;
            end else if ((r_state == S_SAMPLE) && frame_tick) begin
               if (r_smp_cnt == '0) begin
                  r_min[a] <= w_axis[a];
                  r_max[a] <= w_axis[a];
               end else begin
                  if (w_axis[a] < r_min[a]) r_min[a] <= w_axis[a];
                  if (w_axis[a] > r_max[a]) r_max[a] <= w_axis[a];
               end
            end
         end
      end
   end

   always_comb begin
      w_reject = 1'b0;
      for (int a = 0; a < 4; a++) begin
         if ((r_max[a] - r_min[a]) > 8'(MAX_SPREAD)) begin
            w_reject = 1'b1;
         end
      end
   end

   // Sticky until the next arming so software can read it after the sequence ends.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cal_error <= 1'b0;
      end else if (w_arm) begin
         r_cal_error <= 1'b0;
      end else if ((r_state == S_CHECK) && w_reject) begin
         r_cal_error <= 1'b1;
      end
   end

   assign cal_error = r_cal_error;
`else
   assign w_reject  = 1'b0;
   assign cal_error = 1'b0;
`endif

   assign joy_x_center     = r_center[0];
   assign joy_y_center     = r_center[1];
   assign c_stick_x_center = r_center[2];
   assign c_stick_y_center = r_center[3];
   assign cal_busy         = (r_state != S_IDLE);
   assign cal_done         = r_cal_done;

endmodule

// File: tb/tb_stick_center_calibrator.sv
// Self-checking bench for stick_center_calibrator: tick-numbered behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized calibration attempts.
module tb_stick_center_calibrator;

   localparam int DEB    = 3;
   localparam int SETTLE = 4;
   localparam int LOG2   = 3;
   localparam int NSAMP  = 1 << LOG2;
   localparam int SPREAD = 6;
   localparam int NTICKS = DEB + SETTLE + NSAMP;
`ifdef STICK_SPREAD_CHECK_EN
   localparam bit SPREAD_EN = 1'b1;
`else
   localparam bit SPREAD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_pause = 1'b0;
   logic [7:0] joy_x = 8'd0;
   logic [7:0] joy_y = 8'd0;
   logic [7:0] c_stick_x = 8'd0;
   logic [7:0] c_stick_y = 8'd0;
   logic [7:0] joy_x_center;
   logic [7:0] joy_y_center;
   logic [7:0] c_stick_x_center;
   logic [7:0] c_stick_y_center;
   logic       cal_busy;
   logic       cal_done;
   logic       cal_error;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   stick_center_calibrator #(
      .DEBOUNCE_FRAMES (DEB),
      .SETTLE_FRAMES   (SETTLE),
      .SAMPLE_LOG2     (LOG2),
      .MAX_SPREAD      (SPREAD)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .frame_tick       (frame_tick),
      .start_pause      (start_pause),
      .joy_x            (joy_x),
      .joy_y            (joy_y),
      .c_stick_x        (c_stick_x),
      .c_stick_y        (c_stick_y),
      .joy_x_center     (joy_x_center),
      .joy_y_center     (joy_y_center),
      .c_stick_x_center (c_stick_x_center),
      .c_stick_y_center (c_stick_y_center),
      .cal_busy         (cal_busy),
      .cal_done         (cal_done),
      .cal_error        (cal_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a calibration is a numbered run of accepted frame ticks.
   // Ticks 1..DEB need start_pause, the next SETTLE are discarded, the next NSAMP are samples.
   bit m_valid = 1'b0;
   bit m_busy, m_wait_rel, m_check, m_done, m_err, m_reject;
   int m_ticks, m_ns;
   int m_center [4];
   int m_avg    [4];
   int m_samp   [4][NSAMP];
   int m_ax     [4];
   int m_sum, m_mn, m_mx;

   always @(posedge clk) begin
      m_ax[0] = int'(joy_x);
      m_ax[1] = int'(joy_y);
      m_ax[2] = int'(c_stick_x);
      m_ax[3] = int'(c_stick_y);
      if (!rst_n) begin
         m_valid    = 1'b1;
         m_busy     = 1'b0;
         m_wait_rel = 1'b0;
         m_check    = 1'b0;
         m_done     = 1'b0;
         m_err      = 1'b0;
         m_ticks    = 0;
         m_ns       = 0;
         for (int a = 0; a < 4; a++) m_center[a] = 128;
      end else begin
         m_done = 1'b0;
         if (m_check) begin
            m_reject = 1'b0;
            for (int a = 0; a < 4; a++) begin
               m_sum = 0;
               m_mn  = 255;
               m_mx  = 0;
               for (int s = 0; s < NSAMP; s++) begin
                  m_sum += m_samp[a][s];
                  if (m_samp[a][s] < m_mn) m_mn = m_samp[a][s];
                  if (m_samp[a][s] > m_mx) m_mx = m_samp[a][s];
               end
               if (SPREAD_EN && (m_mx - m_mn > SPREAD)) m_reject = 1'b1;
               m_avg[a] = m_sum / NSAMP;
            end
            if (m_reject) begin
               m_err = 1'b1;
            end else begin
               for (int a = 0; a < 4; a++) m_center[a] = m_avg[a];
               m_done = 1'b1;
            end
            m_check    = 1'b0;
            m_wait_rel = 1'b1;
         end else if (frame_tick) begin
            if (!m_busy) begin
               if (start_pause) begin
                  m_busy  = 1'b1;
                  m_ticks = 1;
                  m_ns    = 0;
                  m_err   = 1'b0;
               end
            end else if (m_wait_rel) begin
               if (!start_pause) begin
                  m_busy     = 1'b0;
                  m_wait_rel = 1'b0;
               end
            end else begin
               m_ticks++;
               if (m_ticks <= DEB && !start_pause) begin
                  m_busy = 1'b0;
               end else if (m_ticks > DEB + SETTLE) begin
                  for (int a = 0; a < 4; a++) m_samp[a][m_ns] = m_ax[a];
                  m_ns++;
                  if (m_ns == NSAMP) m_check = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model cal_busy",         cal_busy,         m_busy);
         check("model cal_done",         cal_done,         m_done);
         check("model cal_error",        cal_error,        m_err);
         check("model joy_x_center",     joy_x_center,     m_center[0]);
         check("model joy_y_center",     joy_y_center,     m_center[1]);
         check("model c_stick_x_center", c_stick_x_center, m_center[2]);
         check("model c_stick_y_center", c_stick_y_center, m_center[3]);
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_tick(input bit sp, input int jx, input int jy, input int cx, input int cy,
                          input int gap);
      start_pause = sp;
      joy_x       = 8'(jx);
      joy_y       = 8'(jy);
      c_stick_x   = 8'(cx);
      c_stick_y   = 8'(cy);
      frame_tick  = 1'b1;
      cycles(1);
      frame_tick  = 1'b0;
      cycles(gap);
   endtask

   task automatic arm_and_settle(input int jx, input int jy, input int cx, input int cy);
      for (int t = 0; t < DEB + SETTLE; t++) do_tick(1'b1, jx, jy, cx, cy, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int base [4];
   int jit;
   bit sp;

   initial begin
      // Reset
      rst_n = 1'b0;
      cycles(2);
      check("reset joy_x_center",     joy_x_center,     128);
      check("reset c_stick_y_center", c_stick_y_center, 128);
      check("reset cal_busy",  cal_busy,  0);
      check("reset cal_done",  cal_done,  0);
      check("reset cal_error", cal_error, 0);
      rst_n = 1'b1;
      cycles(1);

      // Nominal: 15 ticks with start_pause held, constant axes
      for (int t = 0; t < NTICKS; t++) begin
         do_tick(1'b1, 140, 120, 100, 150, (t == NTICKS - 1) ? 0 : 2);
      end
      check("nominal cal_done k+1", cal_done, 0);
      check("nominal centers unchanged k+1", joy_x_center, 128);
      cycles(1);
      check("nominal cal_done k+2", cal_done, 1);
      check("nominal joy_x_center",     joy_x_center,     140);
      check("nominal joy_y_center",     joy_y_center,     120);
      check("nominal c_stick_x_center", c_stick_x_center, 100);
      check("nominal c_stick_y_center", c_stick_y_center, 150);
      cycles(1);
      check("nominal cal_done k+3", cal_done, 0);
      check("nominal busy held", cal_busy, 1);
      do_tick(1'b0, 140, 120, 100, 150, 1);
      check("nominal released busy", cal_busy, 0);

      // Averaging truncation: 1044 / 8 -> 130
      arm_and_settle(130, 120, 100, 150);
      for (int s = 0; s < NSAMP; s++) begin
         do_tick(1'b1, 130 + (s % 2), 120, 100, 150, (s == NSAMP - 1) ? 0 : 1);
      end
      cycles(1);
      check("trunc cal_done", cal_done, 1);
      check("trunc joy_x_center", joy_x_center, 130);
      do_tick(1'b0, 130, 120, 100, 150, 1);

      // Bounce: released on the third debounce tick
      do_tick(1'b1, 90, 90, 90, 90, 1);
      do_tick(1'b1, 90, 90, 90, 90, 1);
      do_tick(1'b0, 90, 90, 90, 90, 1);
      check("bounce busy", cal_busy, 0);
      cycles(3);
      check("bounce busy later", cal_busy, 0);
      check("bounce joy_x_center", joy_x_center, 130);

      // Spread: c_stick_y alternates 120/130
      arm_and_settle(130, 120, 100, 125);
      for (int s = 0; s < NSAMP; s++) begin
         do_tick(1'b1, 130, 120, 100, (s % 2) ? 130 : 120, (s == NSAMP - 1) ? 0 : 1);
      end
      cycles(1);
`ifdef STICK_SPREAD_CHECK_EN
      check("spread cal_error", cal_error, 1);
      check("spread no cal_done", cal_done, 0);
      check("spread c_stick_y_center kept", c_stick_y_center, 150);
`else
      check("spread cal_error", cal_error, 0);
      check("spread cal_done", cal_done, 1);
      check("spread c_stick_y_center", c_stick_y_center, 125);
`endif
      do_tick(1'b0, 130, 120, 100, 125, 1);

      // Reset after 4 samples, then a clean calibration
      arm_and_settle(200, 200, 200, 200);
      for (int s = 0; s < 4; s++) do_tick(1'b1, 200, 200, 200, 200, 1);
      rst_n       = 1'b0;
      frame_tick  = 1'b1;
      start_pause = 1'b1;
      cycles(2);
      frame_tick  = 1'b0;
      start_pause = 1'b0;
      check("midreset joy_x_center", joy_x_center, 128);
      check("midreset busy", cal_busy, 0);
      check("midreset cal_error", cal_error, 0);
      rst_n = 1'b1;
      cycles(1);
      arm_and_settle(10, 50, 50, 50);
      for (int s = 0; s < NSAMP; s++) begin
         do_tick(1'b1, 10 * (s + 1), 50, 50, 50, (s == NSAMP - 1) ? 0 : 1);
      end
      cycles(1);
      check("fresh cal_done", cal_done, 1);
      check("fresh joy_x_center", joy_x_center, 45);
      check("fresh joy_y_center", joy_y_center, 50);
      do_tick(1'b0, 50, 50, 50, 50, 1);

      // Randomized attempts checked by the model
      for (int trial = 0; trial < 40; trial++) begin
         for (int a = 0; a < 4; a++) base[a] = $urandom_range(20, 235);
         jit = ($urandom_range(0, 3) == 0) ? 12 : $urandom_range(0, 4);
         for (int t = 0; t < 24; t++) begin
            sp = ($urandom_range(0, 15) != 0);
            do_tick(sp, base[0] + $urandom_range(0, jit), base[1] + $urandom_range(0, jit),
                    base[2] + $urandom_range(0, jit), base[3] + $urandom_range(0, jit),
                    $urandom_range(0, 3));
         end
         if ($urandom_range(0, 7) == 0) begin
            rst_n = 1'b0;
            cycles(1);
            rst_n = 1'b1;
         end
         do_tick(1'b0, 0, 0, 0, 0, 1);
         do_tick(1'b0, 0, 0, 0, 0, 1);
      end

      cycles(3);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stick_center_calibrator.md
# stick_center_calibrator

- Sequences rest-position calibration for the main stick and C-stick on a frame-by-frame basis.
- On a debounced start_pause press, it:
  - waits for the sticks to settle;
  - averages 2^SAMPLE_LOG2 per-frame samples of all four axes;
  - optionally rejects the result if any axis moved;
  - publishes the four 8-bit center values.
- Sits between the controller decoder and the stick display logic, which consume the centers as registered inputs.

## Interface
Parameters:
- DEBOUNCE_FRAMES, 3, consecutive frame_ticks start_pause must be high to arm
- SETTLE_FRAMES, 4, frame_ticks discarded after arming
- SAMPLE_LOG2, 3, log2 of sample count (8 samples)
- MAX_SPREAD, 6, max allowed per-axis (max - min) when spread check compiled in

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  reset; synchronous and active-low
- frame_tick  in  1  one-cycle pulse per video frame
- start_pause  in  1  calibrate request (level, raw)
- joy_x, joy_y, c_stick_x, c_stick_y  in  8 each  raw axis values
- joy_x_center, joy_y_center, c_stick_x_center, c_stick_y_center  out  8 each  published centers; reset 128
- cal_busy  out  1  high in any state except IDLE; reset 0
- cal_done  out  1  one-cycle pulse on successful commit; reset 0
- cal_error  out  1  sticky reject flag; reset 0

## Operation
FSM states and transitions:
- **IDLE**
  - frame_tick with start_pause=1: DEBOUNCE, debounce count=1; clear cal_error.
  - If DEBOUNCE_FRAMES=1: go directly to SETTLE.
- **DEBOUNCE**
  - frame_tick with start_pause=0: IDLE.
  - frame_tick with start_pause=1: increment; at count==DEBOUNCE_FRAMES go to SETTLE, counter cleared.
- **SETTLE**
  - Count frame_ticks; at SETTLE_FRAMES go to SAMPLE, clearing accumulators and min/max.
  - start_pause ignored.
- **SAMPLE**
  - Each frame_tick: add each axis to its (8+SAMPLE_LOG2)-bit accumulator and update per-axis min/max.
  - On the 2^SAMPLE_LOG2-th sample: CHECK.
  - start_pause ignored.
- **CHECK** (exactly one cycle; frame_tick ignored)
  - Spread fails: set cal_error, centers unchanged.
  - Otherwise: center <= accumulator >> SAMPLE_LOG2 (truncating) for all four axes simultaneously; pulse cal_done.
  - Next state: WAIT_RELEASE.
- **WAIT_RELEASE**
  - frame_tick with start_pause=0: IDLE.
  - Prevents re-triggering while held.

Arithmetic and boundaries:
- Accumulators never overflow: 8 × 255 = 2040 fits in 11 bits.
- min/max initialize to the first sample.
- Centers change only in CHECK; all four update on the same edge, never partially.
- rst_n low on any edge, including mid-SAMPLE: state IDLE, centers 128, all flags 0, accumulators cleared.

## Timing
Latency:
- Let cycle k be the cycle holding the final sample's frame_tick.
- CHECK occurs in cycle k+1.
- Centers, cal_done and cal_error are visible in cycle k+2.
- cal_done is high for exactly cycle k+2.

Per-frame timing:
- Nominal calibration = DEBOUNCE_FRAMES + SETTLE_FRAMES + 2^SAMPLE_LOG2 frame_ticks (15 by default).
- Only one frame_tick is acted on per cycle.
- frame_tick is ignored in any cycle where rst_n=0.

Flag timing:
- cal_busy rises the cycle after the arming frame_tick.
- cal_busy falls the cycle after the releasing frame_tick.
- cal_error holds until the next IDLE→DEBOUNCE transition or reset.

## Configuration
- STICK_SPREAD_CHECK_EN defined:
  - min/max trackers instantiated.
  - CHECK rejects if any axis has max - min > MAX_SPREAD.
  - On reject, cal_error=1 and no cal_done pulse.
- Undefined:
  - No min/max logic.
  - CHECK always commits.
  - cal_error tied to 0.

## Test plan
- Reset: rst_n=0 two cycles → all centers 128, cal_busy=0, cal_done=0, cal_error=0.
- Nominal calibration:
  - Stimulus: start_pause held, axes constant joy=(140,120), c=(100,150).
  - Response: after the 15th frame_tick, centers become 140/120/100/150 two cycles later; one cal_done pulse.
  - Release start_pause → IDLE.
- Averaging truncation: joy_x samples 130,131,130,131,130,131,130,131 (sum 1044) → joy_x_center=130.
- Bounce: start_pause high on 2 ticks, low on the 3rd → IDLE, no cal_busy beyond, centers unchanged.
- Spread reject (macro defined):
  - Stimulus: c_stick_y alternates 120/130 during SAMPLE (spread 10 > 6).
  - Response: cal_error=1, no cal_done, centers keep prior values.
  - Same stimulus without macro → commit, c_stick_y_center=125.
- Reset mid-SAMPLE: rst_n=0 after 4 samples → centers 128, IDLE. A fresh calibration then completes correctly with a new 8-sample average, with no residue from the earlier samples.
